imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/aquila_pkg.sv | 21 ++
 rtl/imem_array.sv | 26 ++
 rtl/imem_responder.sv | 102 ++++++++++
 3 files changed

// File: rtl/aquila_pkg.sv
// Shared constants and types for the aquila instruction-fetch path.
// Imported by the fetch responder and its backing array.
package aquila_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic valid;
        logic err;
    } resp_tag_t;

    // Word-aligned and inside a depth-word array.
    function automatic logic addr_ok(
        input logic [XLEN-1:0] a,
        input int unsigned     depth
    );
        return (a[1:0] == 2'b00) && ((a >> 2) < depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-clock synchronous RAM, one read and one write port, read-first.
// Contents are never reset.
module imem_array
    import aquila_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction memory responder with flush and program load.
// The RAM read is the first stage; LATENCY-1 further stages follow it.
module imem_responder
    import aquila_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_req,
    input  logic [XLEN-1:0] imem_addr,
    input  logic            flush,
    output logic [XLEN-1:0] imem_rdata,
    output logic            imem_valid,
    output logic            imem_err,
    input  logic            ld_en,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [XLEN-1:0] ld_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("imem_responder: LATENCY must be in 1..4");
    end

    if (DEPTH_WORDS < 16 || (1 << AW) != DEPTH_WORDS) begin : g_bad_depth
        $error("imem_responder: DEPTH_WORDS must be a power of two >= 16");
    end

    logic            req_ok;
    logic            ld_ok;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] last_data;
    logic            last_valid;
    resp_tag_t       tag_q [LATENCY];

    assign req_ok = addr_ok(imem_addr, DEPTH_WORDS);
    assign ld_ok  = addr_ok(ld_addr, DEPTH_WORDS);

    imem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .raddr (imem_addr[AW+1:2]),
        .rdata (ram_rdata),
        .we    (ld_en & ld_ok),
        .waddr (ld_addr[AW+1:2]),
        .wdata (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '{valid: 1'b0, err: 1'b0};
            end
        end else begin
            tag_q[0] <= '{valid: imem_req & ~flush, err: ~req_ok};
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= '{
                    valid: tag_q[k-1].valid & ~flush,
                    err:   tag_q[k-1].err
                };
            end
        end
    end

    // Data needs no reset: it is only visible behind a valid tag.
    if (LATENCY == 1) begin : g_lat1
        assign last_data = ram_rdata;
    end else begin : g_latn
        logic [XLEN-1:0] data_q [LATENCY-1];

        always_ff @(posedge clk) begin
            data_q[0] <= ram_rdata;
            for (int k = 1; k < LATENCY - 1; k++) begin
                data_q[k] <= data_q[k-1];
            end
        end

        assign last_data = data_q[LATENCY-2];
    end

    // A flush also hides the response already sitting at the output.
    assign last_valid = tag_q[LATENCY-1].valid & ~flush;

    always_comb begin
        imem_valid = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = NOP_INSTR;
        if (last_valid) begin
            imem_valid = 1'b1;
            imem_err   = tag_q[LATENCY-1].err;
            if (!tag_q[LATENCY-1].err) begin
                imem_rdata = last_data;
            end
        end
    end

endmodule
